// File: rtl/z_buffer_mem.sv
// Depth-buffer memory responder for the rasteriser depth-test unit.
// Serves single-word reads and writes with programmable latency, plus a
// local sweep that clears every entry to all-ones.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting; clear has priority, then write, then read
// RD_WAIT | read accepted, counting down the remaining read latency
// RD_RESP | read data valid, held until the initiator takes it
// WR_WAIT | write accepted, counting down the remaining write latency
// WR_ACK  | one-cycle write acknowledge; memory commits this cycle
// CLEAR   | writing all-ones to one entry per cycle, 0..DEPTH-1
module z_buffer_mem #(
    parameter int                   Z_SIZE        = 8,
    parameter int                   X_RES         = 4,
    parameter int                   Y_RES         = 4,
    parameter int                   ADDR_SIZE     = 32,
    parameter logic [ADDR_SIZE-1:0] BASE_ADDR     = '0,
    parameter int                   READ_LATENCY  = 1,
    parameter int                   WRITE_LATENCY = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 buf_r_w,
    input  logic [ADDR_SIZE-1:0] buf_addr,
    input  logic [Z_SIZE-1:0]    buf_data_w,
    output logic [Z_SIZE-1:0]    buf_data_r,
    input  logic                 data_r_ready,
    output logic                 data_r_valid,
    input  logic                 data_w_valid,
    output logic                 data_w_ready,
    input  logic                 clear_i,
    output logic                 busy_o,
    output logic                 err_o
);

    localparam int DEPTH = X_RES * Y_RES;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = 16;
    // Wait states last LATENCY-1 cycles, so the down-counter starts at LATENCY-2.
    localparam logic [CNT_W-1:0] RD_LOAD = (READ_LATENCY > 1) ? CNT_W'(READ_LATENCY - 2) : '0;
    localparam logic [CNT_W-1:0] WR_LOAD = (WRITE_LATENCY > 1) ? CNT_W'(WRITE_LATENCY - 2) : '0;
    localparam logic [ADDR_SIZE-1:0] DEPTH_A = ADDR_SIZE'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        RD_RESP = 3'd2,
        WR_WAIT = 3'd3,
        WR_ACK  = 3'd4,
        CLEAR   = 3'd5
    } state_t;

    state_t state, state_nxt;

    logic [Z_SIZE-1:0]  mem [DEPTH];
    logic [CNT_W-1:0]   lat_cnt;
    logic [IDX_W-1:0]   lat_idx;
    logic [IDX_W-1:0]   clr_idx;
    logic               lat_ok;
    logic [Z_SIZE-1:0]  lat_data;
    logic [Z_SIZE-1:0]  rd_data;
    logic               clear_pending;
    logic               err;

    // The extra top bit is the borrow: set when the address lies below BASE_ADDR.
    logic [ADDR_SIZE:0] req_diff;
    logic               req_ok;
    logic               clear_req;
    logic               accept_wr;
    logic               accept_rd;
    logic               load_rd;
    logic [IDX_W-1:0]   rd_idx;
    logic               rd_ok;

    assign req_diff  = {1'b0, buf_addr} - {1'b0, BASE_ADDR};
    assign req_ok    = !req_diff[ADDR_SIZE] && (req_diff[ADDR_SIZE-1:0] < DEPTH_A);
    assign clear_req = clear_pending || clear_i;
    assign accept_wr = (state == IDLE) && !clear_req && data_w_valid && !buf_r_w;
    assign accept_rd = (state == IDLE) && !clear_req && data_r_ready && buf_r_w;
    // Read data is fetched on the way into RD_RESP; with single-cycle latency
    // that happens straight from IDLE, before the address has been latched.
    assign load_rd   = (accept_rd && (READ_LATENCY == 1)) || ((state == RD_WAIT) && (lat_cnt == '0));
    assign rd_idx    = (state == IDLE) ? req_diff[IDX_W-1:0] : lat_idx;
    assign rd_ok     = (state == IDLE) ? req_ok : lat_ok;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (clear_req)                      state_nxt = CLEAR;
                else if (data_w_valid && !buf_r_w)  state_nxt = (WRITE_LATENCY == 1) ? WR_ACK : WR_WAIT;
                else if (data_r_ready && buf_r_w)   state_nxt = (READ_LATENCY == 1) ? RD_RESP : RD_WAIT;
            end
            RD_WAIT: if (lat_cnt == '0) state_nxt = RD_RESP;
            RD_RESP: if (data_r_ready)  state_nxt = IDLE;
            WR_WAIT: if (lat_cnt == '0) state_nxt = WR_ACK;
            WR_ACK:                     state_nxt = IDLE;
            CLEAR:   if (clr_idx == LAST_IDX) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        data_r_valid = (state == RD_RESP);
        data_w_ready = (state == WR_ACK);
        busy_o       = (state != IDLE);
        buf_data_r   = rd_data;
        err_o        = err;
    end

    // Request latches, latency timer, clear bookkeeping and sticky error.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lat_cnt       <= '0;
            lat_idx       <= '0;
            lat_ok        <= 1'b0;
            lat_data      <= '0;
            rd_data       <= '0;
            clr_idx       <= '0;
            clear_pending <= 1'b0;
            err           <= 1'b0;
        end else begin
            if (accept_wr || accept_rd) begin
                lat_idx <= req_diff[IDX_W-1:0];
                lat_ok  <= req_ok;
                lat_cnt <= accept_wr ? WR_LOAD : RD_LOAD;
                if (!req_ok) err <= 1'b1;
            end else if (((state == RD_WAIT) || (state == WR_WAIT)) && (lat_cnt != '0)) begin
                lat_cnt <= lat_cnt - 1'b1;
            end
            if (accept_wr) lat_data <= buf_data_w;
            if (load_rd)   rd_data  <= rd_ok ? mem[rd_idx] : '1;
            if (state == CLEAR)
                clr_idx <= (clr_idx == LAST_IDX) ? '0 : clr_idx + 1'b1;
            else
                clr_idx <= '0;
            if ((state == IDLE) && clear_req)
                clear_pending <= 1'b0;
            else if (clear_i && (state != IDLE) && (state != CLEAR))
                clear_pending <= 1'b1;
        end
    end

    // Storage: write commit at the end of WR_ACK, or one clear entry per cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if ((state == WR_ACK) && lat_ok) mem[lat_idx] <= lat_data;
            else if (state == CLEAR)         mem[clr_idx] <= '1;
        end
    end

endmodule

// File: doc/z_buffer_mem.md
Name: z_buffer_mem

Overview:
- On-chip depth-storage responder. Serves the depth-buffer memory protocol issued by the rasteriser's depth-test unit: per-pixel reads, conditional writes and flush sweeps.
- Holds X_RES*Y_RES words of Z_SIZE bits with element (word) addressing relative to BASE_ADDR.
- Adds programmable read/write latency and a local bulk clear, so the depth-test path can be verified and run without external memory.

Parameters:
- Z_SIZE, 8, depth word width
- X_RES, 4, framebuffer width in pixels
- Y_RES, 4, framebuffer height in pixels
- ADDR_SIZE, 32, address width
- BASE_ADDR, 0, address of entry 0; DEPTH = X_RES*Y_RES (derived, not overridable)
- READ_LATENCY, 1, cycles from read accept to data_r_valid (>=1)
- WRITE_LATENCY, 1, cycles from write accept to data_w_ready pulse (>=1)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- buf_r_w  in  1  1 = read, 0 = write
- buf_addr  in  ADDR_SIZE  request address
- buf_data_w  in  Z_SIZE  write data
- buf_data_r  out  Z_SIZE  read data
- data_r_ready  in  1  initiator read request / ready for read data
- data_r_valid  out  1  read data valid
- data_w_valid  in  1  write request valid
- data_w_ready  out  1  write accepted (one-cycle pulse)
- clear_i  in  1  request bulk clear of all entries to all-ones
- busy_o  out  1  high whenever the FSM is not in IDLE
- err_o  out  1  sticky out-of-range access flag

Behaviour:
- Reset values: data_r_valid=0, data_w_ready=0, buf_data_r=0, busy_o=0, err_o=0; FSM=IDLE; latency counter=0; clear_pending=0.
- Memory contents are not reset; software or the flush path initialises them.
- FSM states: IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_ACK, CLEAR.
- IDLE, priority order:
  - clear_pending or clear_i -> CLEAR, clear index = 0.
  - Else data_w_valid && !buf_r_w -> accept write: latch buf_addr and buf_data_w; go WR_ACK if WRITE_LATENCY==1, else WR_WAIT.
  - Else data_r_ready && buf_r_w -> accept read: latch buf_addr; go RD_RESP if READ_LATENCY==1, else RD_WAIT.
- Read/write requests are mutually exclusive through buf_r_w.
- Read timing (accept at cycle T):
  - data_r_valid=1 at T+READ_LATENCY, with buf_data_r = mem[latched_addr - BASE_ADDR].
  - RD_RESP holds valid and data stable until data_r_valid && data_r_ready, then returns to IDLE.
  - data_r_valid is 0 in the following cycle.
  - Deasserting data_r_ready in RD_RESP stalls; it never drops valid.
- Write timing (accept at cycle T):
  - data_w_ready=1 for exactly one cycle at T+WRITE_LATENCY (WR_ACK); the memory write commits at the end of that cycle.
  - Returns to IDLE; data_w_ready=0 in IDLE.
  - A back-to-back write (initiator keeps data_w_valid=1 with a new address after the handshake) is accepted in the IDLE cycle. Minimum write period = WRITE_LATENCY+1 cycles.
- Write data and address are sampled only at accept; later input changes are ignored.
- Out of range (addr < BASE_ADDR or addr - BASE_ADDR >= DEPTH):
  - Handshake still completes with normal timing.
  - Write is dropped; read returns all-ones.
  - err_o set at accept and held until rst_i.
- Address arithmetic: compute the index as (addr - BASE_ADDR) in ADDR_SIZE bits; compare against DEPTH before indexing; no wrap-around.
- CLEAR:
  - Writes all-ones to one entry per cycle, index 0..DEPTH-1, then returns to IDLE. Exactly DEPTH cycles in CLEAR.
  - No requests are accepted; data_r_valid=0, data_w_ready=0.
- clear_i asserted outside IDLE sets clear_pending. Clear runs after the current transaction completes; pending is cleared on entering CLEAR.
- clear_i held high during CLEAR does not retrigger; clear_pending only sets outside CLEAR.
- rst_i mid-transaction or mid-clear: FSM returns to IDLE, outputs go to reset values, and an in-flight write is not committed. Partially cleared memory stays as is.

Test Plan:
- READ_LATENCY=1, WRITE_LATENCY=1:
  - Write 0x3C to addr BASE+5 -> data_w_ready pulses one cycle, 1 cycle after accept.
  - Read addr 5 -> data_r_valid the cycle after accept, buf_data_r=0x3C.
- READ_LATENCY=3, initiator holds data_r_ready=0 for 2 cycles once valid rises -> valid rises exactly 3 cycles after accept; data and valid stay stable until ready; valid=0 the cycle after the handshake.
- Flush sweep:
  - 16 back-to-back writes of 0xFF to BASE+0..15, data_w_valid held high -> 16 ready pulses, one every 2 cycles.
  - Reads of all entries return 0xFF.
- Pulse clear_i after writing 0x10 at addr 7 -> busy_o high 16 cycles, no ready/valid during that window; read of addr 7 returns 0xFF.
- Write to BASE+16 with data 0x01 -> handshake completes, err_o=1 and stays 1; entry 0 unchanged.
- rst_i asserted in WR_WAIT (WRITE_LATENCY=4) of a write of 0xAA to addr 2 -> all outputs 0 next cycle; a subsequent read of addr 2 returns the prior value, not 0xAA.
